// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite subordinate backed by a word-addressed internal memory: programmable wait states,
// byte-lane write strobing, and the two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned MEM_DEPTH       = 256,
    parameter int unsigned WAIT_STATES     = 0,
    parameter bit          ADDR_LSB_IGNORE = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned MemBytes = MEM_DEPTH * 4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              wr_q;
    logic [3:0]        mask_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic [31:0]       hrdata_q;

    logic [31:0]       mem_q [MEM_DEPTH];

    logic [IdxW-1:0]   haddr_idx;
    logic [IdxW-1:0]   rd_idx;
    logic [31:0]       rd_word;
    logic [3:0]        lane_mask;
    logic              can_accept;
    logic              accept;
    logic              size_bad;
    logic              misaligned;
    logic              addr_oor;
    logic              illegal;
    logic              commit;
    logic              unused_inputs;

    assign haddr_idx  = HADDR[IdxW+1:2];
    assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];

    assign size_bad   = HSIZE > 3'b010;
    assign misaligned = ((HSIZE == 3'b001) && HADDR[0]) ||
                        ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

    // With aliasing only the word index matters; it can still overrun a non-power-of-two depth.
    always_comb begin
        addr_oor = 1'b0;
        if (ADDR_LSB_IGNORE) begin
            addr_oor = 32'(haddr_idx) >= MEM_DEPTH;
        end else begin
            addr_oor = HADDR >= 32'(MemBytes);
        end
    end

    assign illegal = size_bad || misaligned || addr_oor;

    always_comb begin
        lane_mask = 4'b0000;
        case (HSIZE)
            3'b000:  lane_mask = 4'b0001 << HADDR[1:0];
            3'b001:  lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign commit = (state_q == StData) && wr_q;

    // Read value for the data phase about to start; a write committing on the same edge to the
    // same word is forwarded so a back-to-back read sees the new data.
    always_comb begin
        rd_idx  = (state_q == StWait) ? idx_q : haddr_idx;
        rd_word = mem_q[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (commit && (idx_q == rd_idx) && mask_q[i]) begin
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            mask_q      <= 4'b0000;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
        end else begin
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= 32'd0;
            unique case (state_q)
                StIdle, StData, StErr2: begin
                    if (accept) begin
                        idx_q  <= haddr_idx;
                        wr_q   <= HWRITE;
                        mask_q <= lane_mask;
                        if (illegal) begin
                            state_q     <= StErr1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else if (WAIT_STATES != 0) begin
                            state_q     <= StWait;
                            cnt_q       <= 4'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                        end else begin
                            state_q <= StData;
                            if (!HWRITE) begin
                                hrdata_q <= rd_word;
                            end
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StData;
                        if (!wr_q) begin
                            hrdata_q <= rd_word;
                        end
                    end else begin
                        cnt_q       <= cnt_q - 4'd1;
                        hreadyout_q <= 1'b0;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    hresp_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR};

endmodule
